// File: rtl/reg_share_arbiter_if.sv
// Request/grant bundle between requesters and the shared-register arbiter.
// master = requester side, slave = arbiter side.
interface reg_share_arbiter_if #(
    parameter int N = 4,
    parameter int W = 8
);
    logic [N-1:0]   REQ;
    logic [N*W-1:0] DIN;
    logic [N-1:0]   GNT;
    logic [N-1:0]   ACK;
    logic [W-1:0]   Q;
    logic           BUSY;
    logic [7:0]     WCOUNT;

    modport master (
        output REQ, DIN,
        input  GNT, ACK, Q, BUSY, WCOUNT
    );

    modport slave (
        input  REQ, DIN,
        output GNT, ACK, Q, BUSY, WCOUNT
    );
endinterface

// File: rtl/reg_share_arbiter.sv
// Round-robin arbiter granting N requesters write access to one W-bit register.
// IDLE -> GRANT -> ACK, one write per three cycles at best.
module reg_share_arbiter #(
    parameter int N = 4,
    parameter int W = 8
) (
    input logic               CLK,
    input logic               RST_N,
    reg_share_arbiter_if.slave bus
);
    localparam int PW = (N > 1) ? $clog2(N) : 1;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_GRANT,
        ST_ACK
    } state_t;

    state_t        r_state;
    logic [N-1:0]  r_gnt;
    logic [N-1:0]  r_ack;
    logic [W-1:0]  r_q;
    logic [7:0]    r_wcount;
    logic [PW-1:0] r_ptr;
    logic [PW-1:0] r_idx;

    logic          w_found;
    logic [PW-1:0] w_win;
    logic [PW-1:0] w_j;
    logic          w_hold;
    logic [PW-1:0] w_next_ptr;

    // First requester at or after the pointer, wrapping at N.
    always_comb begin
        w_found = 1'b0;
        w_win   = '0;
        w_j     = '0;
        for (int k = 0; k < N; k++) begin
            w_j = PW'((int'(r_ptr) + k) % N);
            if (!w_found && bus.REQ[w_j]) begin
                w_found = 1'b1;
                w_win   = w_j;
            end
        end
    end

    assign w_hold     = bus.REQ[r_idx];
    assign w_next_ptr = (r_idx == PW'(N - 1)) ? '0 : r_idx + PW'(1);

    always_ff @(posedge CLK) begin
        if (!RST_N) begin
            r_state  <= ST_IDLE;
            r_gnt    <= '0;
            r_ack    <= '0;
            r_q      <= '0;
            r_wcount <= '0;
            r_ptr    <= '0;
            r_idx    <= '0;
        end else begin
            unique case (r_state)
                ST_IDLE: begin
                    r_ack <= '0;
                    if (w_found) begin
                        r_gnt   <= N'(1) << w_win;
                        r_idx   <= w_win;
                        r_state <= ST_GRANT;
                    end else begin
                        r_gnt <= '0;
                    end
                end
                ST_GRANT: begin
                    r_gnt <= '0;
                    // A dropped request aborts without moving the pointer.
                    if (w_hold) begin
                        r_q      <= bus.DIN[r_idx*W +: W];
                        r_ack    <= r_gnt;
                        r_wcount <= r_wcount + 8'd1;
                        r_ptr    <= w_next_ptr;
                        r_state  <= ST_ACK;
                    end else begin
                        r_state <= ST_IDLE;
                    end
                end
                ST_ACK: begin
                    r_ack   <= '0;
                    r_state <= ST_IDLE;
                end
                default: begin
                    r_gnt   <= '0;
                    r_ack   <= '0;
                    r_state <= ST_IDLE;
                end
            endcase
        end
    end

    assign bus.GNT    = r_gnt;
    assign bus.ACK    = r_ack;
    assign bus.Q      = r_q;
    assign bus.BUSY   = (r_state != ST_IDLE);
    assign bus.WCOUNT = r_wcount;
endmodule

// File: tb/tb_reg_share_arbiter.sv
// Self-checking bench for reg_share_arbiter: directed scenarios plus a
// randomized requester population checked against a transaction-level model.
module tb_reg_share_arbiter;
    localparam int N = 4;
    localparam int W = 8;

    logic CLK = 1'b0;
    logic RST_N = 1'b0;

    reg_share_arbiter_if #(.N(N), .W(W)) bus ();

    reg_share_arbiter #(.N(N), .W(W)) dut (
        .CLK   (CLK),
        .RST_N (RST_N),
        .bus   (bus)
    );

    always #5 CLK = ~CLK;

    int n_tests = 0;
    int n_fail  = 0;

    logic [N-1:0]   req;
    logic [N*W-1:0] din;

    // Reference model: who owns the register, and what has been written.
    int           m_phase;
    int           m_g;
    int           m_ptr;
    logic [W-1:0] m_q;
    logic [7:0]   m_cnt;
    logic [N-1:0] m_gnt;
    logic [N-1:0] m_ack;

    function automatic void model_step(input logic rst_n);
        if (!rst_n) begin
            m_phase = 0; m_g = 0; m_ptr = 0;
            m_q = '0; m_cnt = '0; m_gnt = '0; m_ack = '0;
            return;
        end
        case (m_phase)
            0: begin
                m_ack = '0;
                m_gnt = '0;
                for (int k = 0; k < N; k++) begin
                    int i;
                    i = (m_ptr + k) % N;
                    if (req[i]) begin
                        m_g = i;
                        m_gnt[i] = 1'b1;
                        m_phase = 1;
                        break;
                    end
                end
            end
            1: begin
                m_gnt = '0;
                if (req[m_g]) begin
                    m_q = din[m_g*W +: W];
                    m_ack = '0;
                    m_ack[m_g] = 1'b1;
                    m_cnt = m_cnt + 8'd1;
                    m_ptr = (m_g + 1) % N;
                    m_phase = 2;
                end else begin
                    m_phase = 0;
                end
            end
            default: begin
                m_ack = '0;
                m_phase = 0;
            end
        endcase
    endfunction

    // Apply inputs for the coming rising edge, then settle at the falling edge.
    task automatic cyc(input logic rst_n);
        bus.REQ = req;
        bus.DIN = din;
        RST_N   = rst_n;
        model_step(rst_n);
        @(negedge CLK);
    endtask

    // Protocol-following requesters: hold until ACK, drop during ACK.
    task automatic agent(input int abort_pct);
        for (int i = 0; i < N; i++) begin
            if (m_ack[i]) begin
                req[i] = 1'b0;
            end else if (!req[i]) begin
                if ($urandom_range(99) < 30) begin
                    req[i] = 1'b1;
                    din[i*W +: W] = W'($urandom);
                end
            end else if ($urandom_range(99) < abort_pct) begin
                req[i] = 1'b0;
            end
        end
    endtask

    task automatic do_reset();
        req = '0;
        din = '0;
        cyc(1'b0);
        cyc(1'b0);
    endtask

    task automatic test_reset();
        do_reset();
        n_tests++;
        if ({bus.GNT, bus.ACK, bus.Q, bus.WCOUNT, bus.BUSY} !== '0) begin
            n_fail++;
            $display("FAIL reset_state got gnt=%b ack=%b q=%h wc=%0d busy=%b exp all 0",
                     bus.GNT, bus.ACK, bus.Q, bus.WCOUNT, bus.BUSY);
        end
    endtask

    task automatic test_single();
        do_reset();
        req = 4'b0001;
        din[0 +: W] = 8'hA5;
        cyc(1'b1);
        n_tests++;
        if (bus.GNT !== 4'b0001 || bus.ACK !== 4'b0000 || bus.BUSY !== 1'b1) begin
            n_fail++;
            $display("FAIL single_grant got gnt=%b ack=%b busy=%b exp gnt=0001 ack=0000 busy=1",
                     bus.GNT, bus.ACK, bus.BUSY);
        end
        cyc(1'b1);
        n_tests++;
        if (bus.Q !== 8'hA5 || bus.ACK !== 4'b0001 || bus.GNT !== 4'b0000 ||
            bus.WCOUNT !== 8'd1 || bus.BUSY !== 1'b1) begin
            n_fail++;
            $display("FAIL single_write got q=%h ack=%b gnt=%b wc=%0d busy=%b exp q=a5 ack=0001 gnt=0000 wc=1 busy=1",
                     bus.Q, bus.ACK, bus.GNT, bus.WCOUNT, bus.BUSY);
        end
        req = '0;
        cyc(1'b1);
        n_tests++;
        if (bus.BUSY !== 1'b0 || bus.ACK !== 4'b0000 || bus.Q !== 8'hA5) begin
            n_fail++;
            $display("FAIL single_idle got busy=%b ack=%b q=%h exp busy=0 ack=0000 q=a5",
                     bus.BUSY, bus.ACK, bus.Q);
        end
    endtask

    task automatic test_contention();
        logic [W-1:0] exp_q [4];
        logic [N-1:0] exp_ack;
        int seen;
        int last;
        exp_q = '{8'h11, 8'h22, 8'h33, 8'h44};
        do_reset();
        din = {8'h44, 8'h33, 8'h22, 8'h11};
        req = '1;
        seen = 0;
        last = 0;
        for (int c = 1; c <= 40 && seen < 4; c++) begin
            cyc(1'b1);
            if (bus.ACK !== '0) begin
                exp_ack = N'(1) << seen;
                n_tests++;
                if (bus.ACK !== exp_ack || bus.Q !== exp_q[seen]) begin
                    n_fail++;
                    $display("FAIL contention_order got ack=%b q=%h exp ack=%b q=%h",
                             bus.ACK, bus.Q, exp_ack, exp_q[seen]);
                end
                n_tests++;
                if (c - last !== ((seen == 0) ? 2 : 3)) begin
                    n_fail++;
                    $display("FAIL contention_spacing got %0d cycles exp %0d",
                             c - last, (seen == 0) ? 2 : 3);
                end
                last = c;
                seen++;
            end
            req = req & ~m_ack;
        end
        n_tests++;
        if (seen !== 4) begin
            n_fail++;
            $display("FAIL contention_count got %0d writes exp 4", seen);
        end
    endtask

    task automatic test_fairness();
        logic [N-1:0] exp_ack;
        int seen;
        do_reset();
        din = {8'hD3, 8'hC2, 8'hB1, 8'hA0};
        req = 4'b0101;
        seen = 0;
        for (int c = 0; c < 60 && seen < 6; c++) begin
            cyc(1'b1);
            if (bus.ACK !== '0) begin
                exp_ack = (seen % 2 == 0) ? 4'b0001 : 4'b0100;
                n_tests++;
                if (bus.ACK !== exp_ack) begin
                    n_fail++;
                    $display("FAIL fairness_alt got ack=%b exp %b", bus.ACK, exp_ack);
                end
                seen++;
            end
            for (int i = 0; i < N; i++)
                req[i] = (i == 0 || i == 2) && !m_ack[i];
        end
        n_tests++;
        if (seen !== 6) begin
            n_fail++;
            $display("FAIL fairness_count got %0d writes exp 6", seen);
        end
    endtask

    task automatic test_abort();
        do_reset();
        din = {8'h04, 8'h03, 8'h5C, 8'h01};
        req = 4'b0010;
        cyc(1'b1);
        n_tests++;
        if (bus.GNT !== 4'b0010) begin
            n_fail++;
            $display("FAIL abort_grant got gnt=%b exp 0010", bus.GNT);
        end
        req = 4'b0000;
        cyc(1'b1);
        n_tests++;
        if (bus.ACK !== 4'b0000 || bus.Q !== 8'h00 || bus.WCOUNT !== 8'd0 ||
            bus.BUSY !== 1'b0 || bus.GNT !== 4'b0000) begin
            n_fail++;
            $display("FAIL abort_state got ack=%b q=%h wc=%0d busy=%b gnt=%b exp 0000 00 0 0 0000",
                     bus.ACK, bus.Q, bus.WCOUNT, bus.BUSY, bus.GNT);
        end
        req = 4'b0011;
        cyc(1'b1);
        n_tests++;
        if (bus.GNT !== 4'b0001) begin
            n_fail++;
            $display("FAIL abort_ptr got gnt=%b exp 0001", bus.GNT);
        end
    endtask

    task automatic test_reset_mid();
        do_reset();
        din = {8'h88, 8'h77, 8'h66, 8'h55};
        req = 4'b0100;
        cyc(1'b1);
        cyc(1'b1);
        req = 4'b0000;
        cyc(1'b1);
        req = 4'b1000;
        cyc(1'b1);
        n_tests++;
        if (bus.GNT !== 4'b1000 || bus.Q !== 8'h77) begin
            n_fail++;
            $display("FAIL rstmid_setup got gnt=%b q=%h exp gnt=1000 q=77", bus.GNT, bus.Q);
        end
        cyc(1'b0);
        n_tests++;
        if ({bus.GNT, bus.ACK, bus.Q, bus.WCOUNT, bus.BUSY} !== '0) begin
            n_fail++;
            $display("FAIL rstmid_state got gnt=%b ack=%b q=%h wc=%0d busy=%b exp all 0",
                     bus.GNT, bus.ACK, bus.Q, bus.WCOUNT, bus.BUSY);
        end
        req = 4'b1111;
        cyc(1'b1);
        n_tests++;
        if (bus.GNT !== 4'b0001) begin
            n_fail++;
            $display("FAIL rstmid_ptr got gnt=%b exp 0001", bus.GNT);
        end
    endtask

    task automatic test_wrap();
        int idx;
        do_reset();
        for (int w = 0; w < 256; w++) begin
            idx = $urandom_range(N - 1);
            req = N'(1) << idx;
            din[idx*W +: W] = W'($urandom);
            for (int ph = 0; ph < 3; ph++) begin
                if (ph == 2) req = '0;
                cyc(1'b1);
                n_tests++;
                if (!$onehot0(bus.ACK) || !$onehot0(bus.GNT) ||
                    (bus.GNT !== '0 && bus.ACK !== '0) ||
                    bus.ACK !== m_ack || bus.Q !== m_q) begin
                    n_fail++;
                    $display("FAIL wrap_excl w=%0d got gnt=%b ack=%b q=%h exp gnt=%b ack=%b q=%h",
                             w, bus.GNT, bus.ACK, bus.Q, m_gnt, m_ack, m_q);
                end
            end
            if (w == 254) begin
                n_tests++;
                if (bus.WCOUNT !== 8'd255) begin
                    n_fail++;
                    $display("FAIL wrap_255 got wc=%0d exp 255", bus.WCOUNT);
                end
            end
        end
        n_tests++;
        if (bus.WCOUNT !== 8'd0) begin
            n_fail++;
            $display("FAIL wrap_zero got wc=%0d exp 0", bus.WCOUNT);
        end
    endtask

    task automatic test_random();
        logic rst_n;
        do_reset();
        for (int c = 0; c < 3000; c++) begin
            agent(5);
            rst_n = ($urandom_range(199) != 0);
            cyc(rst_n);
            n_tests++;
            if (bus.GNT !== m_gnt || bus.ACK !== m_ack || bus.Q !== m_q ||
                bus.WCOUNT !== m_cnt || bus.BUSY !== (m_phase != 0)) begin
                n_fail++;
                $display("FAIL random c=%0d got gnt=%b ack=%b q=%h wc=%0d busy=%b exp gnt=%b ack=%b q=%h wc=%0d busy=%b",
                         c, bus.GNT, bus.ACK, bus.Q, bus.WCOUNT, bus.BUSY,
                         m_gnt, m_ack, m_q, m_cnt, (m_phase != 0));
            end
        end
    endtask

    initial begin
        req = '0;
        din = '0;
        bus.REQ = '0;
        bus.DIN = '0;
        model_step(1'b0);
        @(negedge CLK);
        test_reset();
        test_single();
        test_contention();
        test_fairness();
        test_abort();
        test_reset_mid();
        test_wrap();
        test_random();
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule

// File: doc/reg_share_arbiter.md
REG_SHARE_ARBITER -- requirements
Module: reg_share_arbiter

Interface
REQ-001 Parameter: N, 4, number of requesters sharing the register (2..8).
REQ-002 Parameter: W, 8, width of the shared D-register.
REQ-003 Port: CLK  input  1  single clock; all state changes on the rising edge.
REQ-004 Port: RST_N  input  1  reset; synchronous, active-low, sampled on the rising edge of CLK.
REQ-005 Port: REQ  input  N  per-requester write request, level.
REQ-006 Port: DIN  input  N*W  packed write data; requester i occupies bits [i*W +: W].
REQ-007 Port: GNT  output  N  one-hot grant, registered.
REQ-008 Port: ACK  output  N  one-hot write-done pulse, registered.
REQ-009 Port: Q  output  W  shared register contents.
REQ-010 Port: BUSY  output  1  high whenever the FSM is not in IDLE.
REQ-011 Port: WCOUNT  output  8  count of completed writes.

Function
REQ-012 The FSM SHALL have the states IDLE, GRANT and ACK; BUSY = (state != IDLE).
REQ-013 IDLE: if any REQ bit is high at an edge, the FSM SHALL select a winner, set GNT to that one-hot value and enter GRANT; otherwise it SHALL stay in IDLE with GNT = 0.
REQ-014 Arbitration SHALL be round-robin: search starts at index PTR and wraps from N-1 to 0; the first index with REQ high wins.
REQ-015 PTR SHALL become (winner+1) mod N only when a write completes; aborted grants SHALL leave PTR unchanged.
REQ-016 GRANT: at the next edge, if REQ[g] is still high, Q SHALL load DIN[g], ACK[g] SHALL go high, WCOUNT SHALL increment, GNT SHALL clear and the FSM SHALL enter ACK.
REQ-017 GRANT with REQ[g] low at that edge (abort): Q, ACK and WCOUNT SHALL be unchanged, GNT SHALL clear and the FSM SHALL enter IDLE.
REQ-018 ACK: ACK SHALL be high for exactly one cycle; at the next edge ACK SHALL clear and the FSM SHALL enter IDLE unconditionally, so there is no arbitration in the ACK state.
REQ-019 Requesters SHALL hold REQ and DIN stable from assertion until ACK is seen, and SHALL drop REQ during the ACK cycle; a REQ still high in IDLE is a new request.
REQ-020 Latency SHALL be as follows: REQ first sampled high at edge k in IDLE gives GNT after edge k, Q update and ACK after edge k+1, and IDLE after edge k+2; peak throughput is one write per 3 cycles.
REQ-021 GNT and ACK SHALL never have more than one bit set, and SHALL never both be nonzero in the same cycle.
REQ-022 Q SHALL change only on a completed write; it SHALL hold its value in all other cycles.
REQ-023 WCOUNT SHALL be unsigned and SHALL wrap from 255 to 0 with no flag.
REQ-024 Requests arriving while BUSY SHALL wait and SHALL NOT disturb the grant in progress.

Reset
REQ-025 RST_N low at an edge SHALL force state=IDLE, GNT=0, ACK=0, Q=0, WCOUNT=0, PTR=0, in any state.
REQ-026 Reset asserted while in GRANT SHALL suppress the pending write: Q unchanged from its reset value 0 and no ACK.
REQ-027 Reset SHALL take priority over every other event on the same edge.

Verification
REQ-028 Single requester: REQ=0001, DIN[0]=8'hA5 -> GNT=0001 one cycle later, then Q=8'hA5 with ACK=0001 for one cycle, WCOUNT=1, BUSY high for 2 cycles.
REQ-029 Contention after reset: REQ=1111 held, each requester dropping REQ in its ACK cycle -> grants in the order 0,1,2,3, Q shows each requester's DIN in turn, writes exactly 3 cycles apart.
REQ-030 Fairness: requesters 0 and 2 held continuously, each re-asserting after its ACK -> grants alternate 0,2,0,2 and neither is starved.
REQ-031 Abort: REQ=0010 then REQ[1] dropped during GRANT -> no ACK, Q unchanged, PTR unchanged; next REQ=0011 -> grant goes to 0.
REQ-032 Reset mid-operation: RST_N=0 during GRANT -> next cycle GNT=0, ACK=0, Q=0, WCOUNT=0, BUSY=0.
REQ-033 Wrap: 256 completed writes -> WCOUNT returns to 0, and ACK stays one-hot throughout.
